// File: rtl/vga_text_renderer_if.sv
// Memory-side bus of the text renderer: character RAM read port and font ROM
// read port. Both memories are synchronous-read with one cycle of latency.
interface vga_text_renderer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic [11:0]       font_addr;
  logic [7:0]        font_data;

  // Renderer side: issues addresses, receives memory data.
  modport master (
    output char_addr,
    output font_addr,
    input  char_data,
    input  font_data
  );

  // Memory side: receives addresses, returns data.
  modport slave (
    input  char_addr,
    input  font_addr,
    output char_data,
    output font_data
  );
endinterface

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode pixel renderer with 8x16 glyphs, fed by the hvsync timing
// generator. Five-cycle fixed pipeline: address, RAM read, font address,
// ROM read, colour select. hsync/vsync are delayed by the same five cycles.
// Optional macro VGA_CURSOR_EN adds a blinking underline cursor.
module vga_text_renderer #(
  parameter int         CHAR_W = 8,
  parameter int         CHAR_H = 16,
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         ADDR_W = 12,
  parameter logic [2:0] FG     = 3'b111,
  parameter logic [2:0] BG     = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          hpos,
  input  logic [9:0]          vpos,
  input  logic                display_on,
  input  logic                hsync_in,
  input  logic                vsync_in,
`ifdef VGA_CURSOR_EN
  input  logic [6:0]          cursor_col,
  input  logic [4:0]          cursor_row,
`endif
  vga_text_renderer_if.master mem,
  output logic [2:0]          rgb,
  output logic                hsync,
  output logic                vsync
);

  localparam int CW = $clog2(CHAR_W);
  localparam int RW = $clog2(CHAR_H);

  logic [9:0]        col_p0, row_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              text_p0;
  logic [RW-1:0]     grow_p1, grow_p2;
  logic [CW-1:0]     px_p1, px_p2, px_p3, px_p4;
  logic              text_p1, text_p2, text_p3, text_p4;
  logic              disp_p1, disp_p2, disp_p3, disp_p4;
  logic [4:0]        hs_dly, vs_dly;
  logic              glyph_bit;

`ifdef VGA_CURSOR_EN
  logic          cur_p0, cur_p1, cur_p2, cur_p3, cur_p4;
  logic [RW-1:0] grow_p3, grow_p4;
  logic [4:0]    frame_cnt;
  logic          blink;
  logic          vs_prev;
`endif

  // Blanking wins over everything; outside the text grid show background.
  function automatic logic [2:0] pixel_colour(input logic disp, input logic text,
                                              input logic pix);
    if (!disp) return 3'b000;
    if (!text) return BG;
    return pix ? FG : BG;
  endfunction

  // Cell coordinates and linear character address from the raw position.
  always_comb begin
    col_p0  = hpos >> CW;
    row_p0  = vpos >> RW;
    addr_p0 = ADDR_W'(32'(row_p0) * COLS + 32'(col_p0));
    text_p0 = display_on && (32'(row_p0) < ROWS) && (32'(col_p0) < COLS);
`ifdef VGA_CURSOR_EN
    cur_p0  = (col_p0 == {3'b000, cursor_col}) && (row_p0 == {5'b00000, cursor_row});
`endif
  end

  // ---- S1: character RAM address and sideband capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mem.char_addr <= '0;
      grow_p1       <= '0;
      px_p1         <= '0;
      text_p1       <= 1'b0;
      disp_p1       <= 1'b0;
    end else begin
      mem.char_addr <= addr_p0;
      grow_p1       <= vpos[RW-1:0];
      px_p1         <= hpos[CW-1:0];
      text_p1       <= text_p0;
      disp_p1       <= display_on;
    end
  end

  // ---- S2: RAM read in flight; sideband follows ----
  always_ff @(posedge clk) begin
    if (reset) begin
      grow_p2 <= '0;
      px_p2   <= '0;
      text_p2 <= 1'b0;
      disp_p2 <= 1'b0;
    end else begin
      grow_p2 <= grow_p1;
      px_p2   <= px_p1;
      text_p2 <= text_p1;
      disp_p2 <= disp_p1;
    end
  end

  // ---- S3: font ROM address from character code and glyph row ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mem.font_addr <= '0;
      px_p3         <= '0;
      text_p3       <= 1'b0;
      disp_p3       <= 1'b0;
    end else begin
      mem.font_addr <= {mem.char_data, 4'(grow_p2)};
      px_p3         <= px_p2;
      text_p3       <= text_p2;
      disp_p3       <= disp_p2;
    end
  end

  // ---- S4: ROM read in flight; sideband follows ----
  always_ff @(posedge clk) begin
    if (reset) begin
      px_p4   <= '0;
      text_p4 <= 1'b0;
      disp_p4 <= 1'b0;
    end else begin
      px_p4   <= px_p3;
      text_p4 <= text_p3;
      disp_p4 <= disp_p3;
    end
  end

  // Pick the pixel from the glyph row; CHAR_W is a power of two, so
  // CHAR_W-1-px is just the bitwise complement of px.
  always_comb begin
    glyph_bit = mem.font_data[~px_p4];
`ifdef VGA_CURSOR_EN
    if (cur_p4 && blink && text_p4 && (grow_p4 >= RW'(CHAR_H - 2)))
      glyph_bit = ~glyph_bit;
`endif
  end

  // ---- S5: colour select and sync delay line ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb    <= 3'b000;
      hs_dly <= '0;
      vs_dly <= '0;
    end else begin
      rgb    <= pixel_colour(disp_p4, text_p4, glyph_bit);
      hs_dly <= {hs_dly[3:0], hsync_in};
      vs_dly <= {vs_dly[3:0], vsync_in};
    end
  end

  assign hsync = hs_dly[4];
  assign vsync = vs_dly[4];

`ifdef VGA_CURSOR_EN
  // Cursor-cell flag and glyph row carried along to the colour stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      {cur_p1, cur_p2, cur_p3, cur_p4} <= 4'b0000;
      grow_p3 <= '0;
      grow_p4 <= '0;
    end else begin
      {cur_p1, cur_p2, cur_p3, cur_p4} <= {cur_p0, cur_p1, cur_p2, cur_p3};
      grow_p3 <= grow_p2;
      grow_p4 <= grow_p3;
    end
  end

  // Frame counter on vsync rising edges; blink phase flips every 32 frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      frame_cnt <= 5'd0;
      blink     <= 1'b1;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) begin
        frame_cnt <= frame_cnt + 5'd1;
        if (frame_cnt == 5'd31) blink <= ~blink;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: two instances (default, and COLS=4 with a
// non-zero background) share one input stream and one memory image. A
// cycle-level reference computes each pixel straight from the text/font
// image and is checked every cycle, alongside directed literal probes.
`timescale 1ns/1ps
module tb_vga_text_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [9:0] hpos = 10'd639, vpos = 10'd479;
  logic       display_on = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
`ifdef VGA_CURSOR_EN
  logic [6:0] cursor_col = 7'd2;
  logic [4:0] cursor_row = 5'd1;
  localparam bit CUR = 1'b1;
`else
  localparam bit CUR = 1'b0;
`endif

  logic [2:0] rgb_a, rgb_b;
  logic       hsync_a, vsync_a, hsync_b, vsync_b;

  vga_text_renderer_if #(.ADDR_W(12)) mem_a();
  vga_text_renderer_if #(.ADDR_W(12)) mem_b();

  vga_text_renderer dut_a (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef VGA_CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
    .mem(mem_a), .rgb(rgb_a), .hsync(hsync_a), .vsync(vsync_a));

  vga_text_renderer #(.COLS(4), .BG(3'b010)) dut_b (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef VGA_CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
    .mem(mem_b), .rgb(rgb_b), .hsync(hsync_b), .vsync(vsync_b));

  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:4095];

  // Synchronous-read memories, one cycle latency.
  always @(posedge clk) begin
    mem_a.char_data <= ram[mem_a.char_addr];
    mem_a.font_data <= rom[mem_a.font_addr];
    mem_b.char_data <= ram[mem_b.char_addr];
    mem_b.font_data <= rom[mem_b.font_addr];
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic rst;
    int   h, v, cc, cr;
    logic d, hs, vs, blink;
  } ent_t;

  ent_t hist[$];
  int   m_cnt = 0;
  logic m_blink = 1'b1, m_prev = 1'b0;

  function automatic int cell_addr(input ent_t e, input int cols);
    return ((e.v / 16) * cols + e.h / 8) % 4096;
  endfunction

  function automatic int exp_rgb(input ent_t e, input int cols, input int bg,
                                 input logic blink);
    int col, row, gr, code;
    logic [7:0] bits;
    logic b;
    col = e.h / 8; row = e.v / 16; gr = e.v % 16;
    if (!e.d) return 0;
    if (row >= 30 || col >= cols) return bg;
    code = int'(ram[12'(cell_addr(e, cols))]);
    bits = rom[12'(code * 16 + gr)];
    b = bits[3'(7 - e.h % 8)];
    if (CUR && col == e.cc && row == e.cr && blink && gr >= 14) b = !b;
    return b ? 7 : bg;
  endfunction

  // Record what each edge sampled; track blink as "32 vsync edges per phase".
  always @(posedge clk) begin
    ent_t e;
    e.rst = reset; e.h = int'(hpos); e.v = int'(vpos);
    e.d = display_on; e.hs = hsync_in; e.vs = vsync_in; e.blink = m_blink;
`ifdef VGA_CURSOR_EN
    e.cc = int'(cursor_col); e.cr = int'(cursor_row);
`else
    e.cc = 0; e.cr = 0;
`endif
    hist.push_front(e);
    if (hist.size() > 8) void'(hist.pop_back());
    if (reset) begin
      m_cnt = 0; m_blink = 1'b1; m_prev = 1'b0;
    end else begin
      if (vsync_in && !m_prev) begin
        m_cnt++;
        if (m_cnt == 32) begin m_cnt = 0; m_blink = !m_blink; end
      end
      m_prev = vsync_in;
    end
  end

  // Per-cycle comparison: output after edge k reflects input of edge k-4.
  always @(negedge clk) begin
    if (hist.size() >= 5) begin
      logic flushed, fa_ok;
      int ea, eb;
      flushed = 1'b0;
      for (int i = 0; i < 5; i++) if (hist[i].rst) flushed = 1'b1;
      fa_ok = !(hist[0].rst || hist[1].rst || hist[2].rst);
      ea = flushed ? 0 : exp_rgb(hist[4], 80, 0, hist[0].blink);
      eb = flushed ? 0 : exp_rgb(hist[4], 4, 2, hist[0].blink);
      check("rgb_a", int'(rgb_a), ea);
      check("rgb_b", int'(rgb_b), eb);
      check("hsync_a", int'(hsync_a), flushed ? 0 : int'(hist[4].hs));
      check("vsync_a", int'(vsync_a), flushed ? 0 : int'(hist[4].vs));
      check("hsync_b", int'(hsync_b), flushed ? 0 : int'(hist[4].hs));
      check("vsync_b", int'(vsync_b), flushed ? 0 : int'(hist[4].vs));
      check("char_addr_a", int'(mem_a.char_addr), hist[0].rst ? 0 : cell_addr(hist[0], 80));
      check("char_addr_b", int'(mem_b.char_addr), hist[0].rst ? 0 : cell_addr(hist[0], 4));
      if (fa_ok) begin
        check("font_addr_a", int'(mem_a.font_addr),
              int'(ram[12'(cell_addr(hist[2], 80))]) * 16 + hist[2].v % 16);
        check("font_addr_b", int'(mem_b.font_addr),
              int'(ram[12'(cell_addr(hist[2], 4))]) * 16 + hist[2].v % 16);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int h, input int v, input logic d, input logic hs,
                      input logic vs);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on = d; hsync_in = hs; vsync_in = vs;
  endtask

  // One pixel, then idle; its colour is visible five negedges later.
  task automatic probe(input string nm, input int h, input int v, input logic d,
                       input int exp_a, input int exp_b);
    step(h, v, d, 1'b0, 1'b0);
    repeat (5) step(0, 0, 1'b0, 1'b0, 1'b0);
    check({nm, "_a"}, int'(rgb_a), exp_a);
    check({nm, "_b"}, int'(rgb_b), exp_b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_hs, cnt_hs;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'((i * 7 + 3) & 255);
      rom[i] = 8'(((i * 37) ^ (i >> 3)) & 255);
    end
    ram[0] = 8'h41; ram[1] = 8'h00; ram[5] = 8'hFF; ram[6] = 8'h00; ram[82] = 8'h00;
    for (int r = 0; r < 16; r++) begin
      rom[r] = 8'h00;
      rom[12'(255 * 16 + r)] = 8'hFF;
    end
    rom[12'h410] = 8'b00011000;

    // Reset held three cycles with busy inputs: everything reads zero.
    repeat (3) begin
      @(negedge clk);
      check("reset_rgb", int'(rgb_a), 0);
      check("reset_hsync", int'(hsync_a), 0);
      check("reset_vsync", int'(vsync_a), 0);
      check("reset_char_addr", int'(mem_a.char_addr), 0);
    end
    step(3, 0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1'b0, 1'b0, 1'b0);
      check("first_pixel_latency", int'(rgb_a), (k == 5) ? 7 : 0);
    end

    // Sweep hpos 0..15 on line 0: glyph 0x41 row 0 lights pixels 3 and 4.
    for (int i = 0; i < 21; i++) begin
      step((i < 16) ? i : 0, 0, i < 16, 1'b0, 1'b0);
      if (i >= 5) begin
        check("sweep_a", int'(rgb_a), (i - 5 == 3 || i - 5 == 4) ? 7 : 0);
        check("sweep_b", int'(rgb_b), (i - 5 == 3 || i - 5 == 4) ? 7 : 2);
      end
    end

    // Last cell address.
    step(639, 479, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    check("last_addr_a", int'(mem_a.char_addr), 2399);
    check("last_addr_b", int'(mem_b.char_addr), 29 * 4 + 79);

    // Full line with the hsync pulse at hpos 656..751.
    first_hs = -1; cnt_hs = 0;
    for (int i = 0; i < 805; i++) begin
      step((i < 800) ? i : 0, 2, i < 640, (i >= 656 && i < 752), 1'b0);
      if (hsync_a) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = i;
      end
    end
    check("hsync_width", cnt_hs, 96);
    check("hsync_start", first_hs, 661);

    // Blanking versus outside-grid background.
    probe("blank_ff", 40, 0, 1'b0, 0, 0);
    probe("col_outside", 40, 0, 1'b1, 7, 2);
    probe("row_outside", 8, 496, 1'b1, 0, 2);

    // Reset pulse in the middle of a line.
    for (int i = 0; i < 40; i++) begin
      step(i, 17, 1'b1, 1'b0, 1'b0);
      reset = (i == 20);
    end
    reset = 1'b0;

    // A few assorted stretches across the screen.
    for (int j = 0; j < 3; j++) begin
      for (int h = 560; h < 660; h++) step(h, (j == 0) ? 33 : (j == 1) ? 130 : 477, h < 640, 1'b0, 1'b0);
    end
    repeat (6) step(0, 0, 1'b0, 1'b0, 1'b0);

`ifdef VGA_CURSOR_EN
    // Cursor at col 2, row 1 underlines glyph rows 14..15, then blinks.
    probe("cursor_on", 18, 30, 1'b1, 7, 7);
    probe("cursor_row13", 18, 29, 1'b1, 0, 2);
    repeat (32) begin
      step(0, 500, 1'b0, 1'b0, 1'b1);
      step(0, 500, 1'b0, 1'b0, 1'b0);
    end
    probe("cursor_off", 18, 30, 1'b1, 0, 2);
    repeat (32) begin
      step(0, 500, 1'b0, 1'b0, 1'b1);
      step(0, 500, 1'b0, 1'b0, 1'b0);
    end
    probe("cursor_back", 18, 31, 1'b1, 7, 7);
`endif

    repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
